// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle for hs_ram_arbiter: CPU port, hiscore engine port, pause lines and the RAM port.
// The arbiter uses the slave modport; the surrounding system uses master.
interface hs_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_cen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              user_pause;
    logic              cpu_pause_n;
    logic              hs_pause_req;
    logic              hs_paused;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_wdata;
    logic              hs_write;
    logic [DATA_W-1:0] hs_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              hs_err;

    modport slave (
        input  cpu_cen, cpu_addr, cpu_wdata, cpu_we, user_pause,
        input  hs_pause_req, hs_addr, hs_wdata, hs_write, ram_rdata,
        output cpu_rdata, cpu_pause_n, hs_paused, hs_rdata,
        output ram_addr, ram_wdata, ram_we, hs_err
    );

    modport master (
        output cpu_cen, cpu_addr, cpu_wdata, cpu_we, user_pause,
        output hs_pause_req, hs_addr, hs_wdata, hs_write, ram_rdata,
        input  cpu_rdata, cpu_pause_n, hs_paused, hs_rdata,
        input  ram_addr, ram_wdata, ram_we, hs_err
    );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the CPU and the hiscore engine; owns the CPU pause line.
// Optional grant watchdog enabled by defining HS_ARB_WATCHDOG_EN.
module hs_ram_arbiter #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned WDOG_CYCLES = 2**20
) (
    input  logic           clk_49m,
    input  logic           reset,
    hs_ram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    if (SETTLE < 1 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("hs_ram_arbiter: SETTLE and WDOG_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, GRANT, RELEASE} state_e;

    state_e            state_q, state_d;
    logic              cen_seen_q, cen_seen_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [DATA_W-1:0] hs_rdata_q, hs_rdata_d;
    logic              hs_err_q, hs_err_d;
    logic              pause_n_q, pause_n_d;
    logic              wdog_expire;
    logic              req_block;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              ram_we_c;
    logic              hs_paused_c;

`ifdef HS_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wblock_q, wblock_d;

    always_comb begin
        wdog_d = '0;
        if (state_q == GRANT) begin
            wdog_d = (wdog_q == WDOG_LAST) ? wdog_q : wdog_q + 1'b1;
        end
    end

    assign wdog_expire = (state_q == GRANT) && (wdog_q == WDOG_LAST);
    // A forced release blocks new requests until the engine drops its request line.
    assign wblock_d    = (wblock_q | wdog_expire) & bus.hs_pause_req;
    assign req_block   = wblock_q;

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            wdog_q   <= '0;
            wblock_q <= 1'b0;
        end else begin
            wdog_q   <= wdog_d;
            wblock_q <= wblock_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign req_block   = 1'b0;
`endif

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cen_seen_q <= 1'b0;
            settle_q   <= '0;
            hs_rdata_q <= '0;
            hs_err_q   <= 1'b0;
            pause_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cen_seen_q <= cen_seen_d;
            settle_q   <= settle_d;
            hs_rdata_q <= hs_rdata_d;
            hs_err_q   <= hs_err_d;
            pause_n_q  <= pause_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.hs_pause_req && !req_block) state_d = DRAIN;
            DRAIN: begin
                if (!bus.hs_pause_req) begin
                    state_d = IDLE;
                end else if (cen_seen_q && settle_q == SETTLE_LAST) begin
                    state_d = GRANT;
                end
            end
            GRANT:   if (!bus.hs_pause_req || wdog_expire) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cen_seen_d = 1'b0;
        settle_d   = '0;
        if (state_q == DRAIN) begin
            cen_seen_d = cen_seen_q | bus.cpu_cen;
            // Settle count starts the cycle after the boundary and saturates.
            if (cen_seen_q) begin
                settle_d = (settle_q == SETTLE_LAST) ? settle_q : settle_q + 1'b1;
            end
        end
        hs_rdata_d = (state_q == GRANT) ? bus.ram_rdata : hs_rdata_q;
        hs_err_d   = hs_err_q | (bus.hs_write & (state_q != GRANT)) | wdog_expire;
        pause_n_d  = ~(bus.user_pause | (state_d != IDLE));
    end

    always_comb begin
        ram_addr_c  = bus.cpu_addr;
        ram_wdata_c = bus.cpu_wdata;
        ram_we_c    = bus.cpu_we & bus.cpu_cen;
        hs_paused_c = 1'b0;
        unique case (state_q)
            DRAIN: ram_we_c = bus.cpu_we & bus.cpu_cen & ~cen_seen_q;
            GRANT: begin
                ram_addr_c  = bus.hs_addr;
                ram_wdata_c = bus.hs_wdata;
                ram_we_c    = bus.hs_write;
                hs_paused_c = 1'b1;
            end
            RELEASE: begin
                ram_addr_c  = bus.hs_addr;
                ram_wdata_c = bus.hs_wdata;
                ram_we_c    = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.ram_addr    = ram_addr_c;
    assign bus.ram_wdata   = ram_wdata_c;
    assign bus.ram_we      = ram_we_c;
    assign bus.hs_paused   = hs_paused_c;
    assign bus.cpu_rdata   = bus.ram_rdata;
    assign bus.hs_rdata    = hs_rdata_q;
    assign bus.hs_err      = hs_err_q;
    // While reset is held the pause follows user_pause without waiting for a clock.
    assign bus.cpu_pause_n = reset ? pause_n_q : ~bus.user_pause;
endmodule
